// File: rtl/call_responder.sv
// call_responder: attendant-station side of the seat call-light interface.
// Presents lit seats one at a time in round-robin order, drives the served
// seat's cancel line after acknowledge, and flags calls left waiting too long.
module call_responder #(
    parameter int N_SEATS    = 8,
    parameter int ID_W       = 3,
    parameter int ESC_CYCLES = 1000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_SEATS-1:0] light_state,
    input  logic               ack,
    output logic               seat_valid,
    output logic [ID_W-1:0]    seat_id,
    output logic [N_SEATS-1:0] cancel,
    output logic               escalate,
    output logic [ID_W:0]      pending_count
);

    localparam int TMR_W = $clog2(ESC_CYCLES + 1);
    localparam logic [TMR_W-1:0] ESC_MAX = TMR_W'(ESC_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        CLEAR
    } state_t;

    state_t             state, state_d;
    logic [N_SEATS-1:0] pend_q;
    logic [ID_W-1:0]    last_q, last_d;
    logic [TMR_W-1:0]   timer, timer_d, timer_inc;
    logic               seat_valid_d;
    logic [ID_W-1:0]    seat_id_d;
    logic [N_SEATS-1:0] cancel_d;
    logic               escalate_d;
    logic [ID_W:0]      count_d;
    logic               sel_found;
    logic [ID_W-1:0]    sel_idx;

    // Timer advances while presenting and parks at the escalation threshold.
    assign timer_inc = (timer == ESC_MAX) ? timer : timer + 1'b1;

    // Round-robin pick: first pending seat after the last one served, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned k = 1; k <= N_SEATS; k++) begin
            if (!sel_found && pend_q[ID_W'((32'(last_q) + k) % N_SEATS)]) begin
                sel_found = 1'b1;
                sel_idx   = ID_W'((32'(last_q) + k) % N_SEATS);
            end
        end
    end

    // Number of lit seats; registered alongside pend_q so both track together.
    always_comb begin
        count_d = '0;
        for (int unsigned i = 0; i < N_SEATS; i++) begin
            count_d = count_d + {{ID_W{1'b0}}, light_state[i]};
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d      = state;
        last_d       = last_q;
        timer_d      = timer;
        seat_valid_d = seat_valid;
        seat_id_d    = seat_id;
        cancel_d     = cancel;
        escalate_d   = escalate;
        case (state)
            IDLE: begin
                seat_valid_d = 1'b0;
                cancel_d     = '0;
                escalate_d   = 1'b0;
                if (sel_found) begin
                    seat_id_d    = sel_idx;
                    timer_d      = '0;
                    seat_valid_d = 1'b1;
                    state_d      = PRESENT;
                end
            end
            PRESENT: begin
                if (!light_state[seat_id]) begin
                    // Seat withdrew its own call; wins over a same-cycle ack.
                    seat_valid_d = 1'b0;
                    escalate_d   = 1'b0;
                    last_d       = seat_id;
                    state_d      = IDLE;
                end else if (ack) begin
                    seat_valid_d      = 1'b0;
                    escalate_d        = 1'b0;
                    cancel_d          = '0;
                    cancel_d[seat_id] = 1'b1;
                    last_d            = seat_id;
                    state_d           = CLEAR;
                end else begin
                    timer_d    = timer_inc;
                    escalate_d = (timer_inc == ESC_MAX);
                end
            end
            CLEAR: begin
                if (!light_state[seat_id]) begin
                    cancel_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                seat_valid_d = 1'b0;
                cancel_d     = '0;
                escalate_d   = 1'b0;
                state_d      = IDLE;
            end
        endcase
    end

    // State, sampled lights and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            pend_q        <= '0;
            last_q        <= ID_W'(N_SEATS - 1);
            timer         <= '0;
            seat_valid    <= 1'b0;
            seat_id       <= '0;
            cancel        <= '0;
            escalate      <= 1'b0;
            pending_count <= '0;
        end else begin
            state         <= state_d;
            pend_q        <= light_state;
            last_q        <= last_d;
            timer         <= timer_d;
            seat_valid    <= seat_valid_d;
            seat_id       <= seat_id_d;
            cancel        <= cancel_d;
            escalate      <= escalate_d;
            pending_count <= count_d;
        end
    end

endmodule

// File: tb/tb_call_responder.sv
// Directed bench for call_responder: a per-cycle vector table covering
// round-robin service, single-call handshake and pending count, plus
// hand-written sequences for self-cancel, escalation and mid-clear reset.
module tb_call_responder;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] light_state = '0;
    logic       ack = 1'b0;
    logic       seat_valid;
    logic [2:0] seat_id;
    logic [7:0] cancel;
    logic       escalate;
    logic [3:0] pending_count;

    call_responder #(
        .N_SEATS   (8),
        .ID_W      (3),
        .ESC_CYCLES(10)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .light_state  (light_state),
        .ack          (ack),
        .seat_valid   (seat_valid),
        .seat_id      (seat_id),
        .cancel       (cancel),
        .escalate     (escalate),
        .pending_count(pending_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] light;
        logic       ack;
        logic       valid;
        logic [2:0] id;
        logic [7:0] cancel;
        logic       esc;
        logic [3:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] l, input logic a, input logic v, input logic [2:0] id,
                       input logic [7:0] c, input logic e, input logic [3:0] n);
        vec_t r;
        r.light = l; r.ack = a; r.valid = v; r.id = id; r.cancel = c; r.esc = e; r.cnt = n;
        vecs.push_back(r);
    endtask

    // Drive one cycle of inputs, let one rising edge pass, sample 1 time unit later.
    task automatic cyc(input logic [7:0] l, input logic a);
        light_state = l;
        ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".valid"}, 32'(seat_valid), 0);
        check({tag, ".id"}, 32'(seat_id), 0);
        check({tag, ".cancel"}, 32'(cancel), 0);
        check({tag, ".escalate"}, 32'(escalate), 0);
        check({tag, ".count"}, 32'(pending_count), 0);
    endtask

    initial begin
        // light, ack -> valid, id (checked only when valid), cancel, escalate, count
        // Round robin from reset: seats 1,3,6 lit; seat 1 relit while 3 is presented.
        add(8'h4A, 0, 0, 3'd0, 8'h00, 0, 4'd3);
        add(8'h4A, 0, 1, 3'd1, 8'h00, 0, 4'd3);
        add(8'h4A, 1, 0, 3'd0, 8'h02, 0, 4'd3);
        add(8'h48, 0, 0, 3'd0, 8'h00, 0, 4'd2);
        add(8'h48, 0, 1, 3'd3, 8'h00, 0, 4'd2);
        add(8'h4A, 0, 1, 3'd3, 8'h00, 0, 4'd3);
        add(8'h4A, 1, 0, 3'd0, 8'h08, 0, 4'd3);
        add(8'h42, 0, 0, 3'd0, 8'h00, 0, 4'd2);
        add(8'h42, 0, 1, 3'd6, 8'h00, 0, 4'd2);
        add(8'h42, 1, 0, 3'd0, 8'h40, 0, 4'd2);
        add(8'h02, 0, 0, 3'd0, 8'h00, 0, 4'd1);
        add(8'h02, 0, 1, 3'd1, 8'h00, 0, 4'd1);
        add(8'h02, 1, 0, 3'd0, 8'h02, 0, 4'd1);
        add(8'h00, 0, 0, 3'd0, 8'h00, 0, 4'd0);
        // Single call on seat 5; ack held into CLEAR and given in IDLE is ignored.
        add(8'h20, 0, 0, 3'd0, 8'h00, 0, 4'd1);
        add(8'h20, 0, 1, 3'd5, 8'h00, 0, 4'd1);
        add(8'h20, 1, 0, 3'd0, 8'h20, 0, 4'd1);
        add(8'h20, 1, 0, 3'd0, 8'h20, 0, 4'd1);
        add(8'h00, 0, 0, 3'd0, 8'h00, 0, 4'd0);
        add(8'h00, 1, 0, 3'd0, 8'h00, 0, 4'd0);
        // All eight lit: count one edge later, next served is seat 6 (after 5).
        add(8'hFF, 0, 0, 3'd0, 8'h00, 0, 4'd8);
        add(8'hFF, 0, 1, 3'd6, 8'h00, 0, 4'd8);
        add(8'hFF, 1, 0, 3'd0, 8'h40, 0, 4'd8);
        add(8'h00, 0, 0, 3'd0, 8'h00, 0, 4'd0);
        add(8'h00, 0, 0, 3'd0, 8'h00, 0, 4'd0);

        // Reset state.
        #1 reset = 1'b1;
        #1 check_all_zero("reset_init");
        cyc(8'h00, 0);
        cyc(8'h00, 0);
        check_all_zero("reset_held");
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].light, vecs[i].ack);
            check($sformatf("vec%0d.valid", i), 32'(seat_valid), 32'(vecs[i].valid));
            if (vecs[i].valid)
                check($sformatf("vec%0d.id", i), 32'(seat_id), 32'(vecs[i].id));
            check($sformatf("vec%0d.cancel", i), 32'(cancel), 32'(vecs[i].cancel));
            check($sformatf("vec%0d.escalate", i), 32'(escalate), 32'(vecs[i].esc));
            check($sformatf("vec%0d.count", i), 32'(pending_count), 32'(vecs[i].cnt));
        end

        // Self-cancel of seat 4 with a same-cycle ack: no cancel, last served = 4.
        cyc(8'h10, 0);
        cyc(8'h10, 0);
        check("sc.valid", 32'(seat_valid), 1);
        check("sc.id", 32'(seat_id), 4);
        cyc(8'h00, 1);
        check("sc.drop_valid", 32'(seat_valid), 0);
        check("sc.drop_cancel", 32'(cancel), 0);
        cyc(8'h00, 0);
        check("sc.after_cancel", 32'(cancel), 0);
        check("sc.after_valid", 32'(seat_valid), 0);
        // Seats 3 and 5 lit: 5 follows 4 in round-robin order.
        cyc(8'h28, 0);
        cyc(8'h28, 0);
        check("sc.next_valid", 32'(seat_valid), 1);
        check("sc.next_id", 32'(seat_id), 5);

        // Escalation: seat 5 just entered PRESENT; flag after exactly 10 edges.
        check("esc.entry", 32'(escalate), 0);
        for (int k = 1; k <= 9; k++) begin
            cyc(8'h28, 0);
            check($sformatf("esc.early%0d", k), 32'(escalate), 0);
        end
        cyc(8'h28, 0);
        check("esc.rise", 32'(escalate), 1);
        for (int k = 0; k < 3; k++) begin
            cyc(8'h28, 0);
            check($sformatf("esc.held%0d", k), 32'(escalate), 1);
            check($sformatf("esc.held_valid%0d", k), 32'(seat_valid), 1);
        end
        cyc(8'h28, 1);
        check("esc.ack_clear", 32'(escalate), 0);
        check("esc.ack_valid", 32'(seat_valid), 0);
        check("esc.ack_cancel", 32'(cancel), 32'h20);
        cyc(8'h08, 0);
        check("esc.cancel_drop", 32'(cancel), 0);
        cyc(8'h00, 0);
        cyc(8'h00, 0);
        cyc(8'h00, 0);
        check("settle.valid", 32'(seat_valid), 0);

        // Reset in the middle of CLEAR for seat 2 drops cancel without a clock edge.
        cyc(8'h04, 0);
        cyc(8'h04, 0);
        check("rst.present_id", 32'(seat_id), 2);
        cyc(8'h04, 1);
        check("rst.cancel_set", 32'(cancel), 32'h04);
        #2 reset = 1'b1;
        #1 check_all_zero("rst.async");
        light_state = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        cyc(8'h00, 0);
        cyc(8'h00, 0);
        check_all_zero("rst.release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
